// File: rtl/mac_rx_ctrl.sv
// Receive-side MAC filter: forwards unicast-to-us frames with a swapped reply header, drops the rest.
// Optional macro MAC_RX_CTRL_BROADCAST_EN also accepts the all-ones destination address.
module mac_rx_ctrl #(
    parameter int                        MAC_ADDR_WIDTH   = 48,
    parameter int                        MAC_HEADER_WIDTH = 112,
    parameter logic [MAC_ADDR_WIDTH-1:0] FPGA_MAC         = 48'h001C24174ACB
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAC_HEADER_WIDTH-1:0] hdr_data,
    input  logic                        hdr_valid,
    input  logic                        msg_valid,
    input  logic                        msg_ready,
    input  logic                        msg_eop,
    output logic                        drop,
    output logic [MAC_HEADER_WIDTH-1:0] out_hdr_data,
    output logic                        out_hdr_valid,
    input  logic                        out_hdr_ready,
    output logic [31:0]                 fwd_cnt,
    output logic [31:0]                 drop_cnt,
    output logic                        hdr_overrun,
    output logic [1:0]                  dbg_state
);

    localparam int ET_W = MAC_HEADER_WIDTH - 2 * MAC_ADDR_WIDTH;

    // Handshakes: a payload beat transfers when msg_valid & msg_ready; the reply
    // header transfers when out_hdr_valid & out_hdr_ready, with data held until then.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FWD_HDR  = 2'd1,
        FWD_BODY = 2'd2,
        DROP     = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic                        eop_flag_q, eop_flag_d;
    logic [MAC_HEADER_WIDTH-1:0] out_hdr_data_q, out_hdr_data_d;
    logic                        out_hdr_valid_q;
    logic                        drop_q;
    logic [31:0]                 fwd_cnt_q, fwd_cnt_d;
    logic [31:0]                 drop_cnt_q, drop_cnt_d;
    logic                        hdr_overrun_q, hdr_overrun_d;

    logic [MAC_ADDR_WIDTH-1:0]   hdr_dst;
    logic [MAC_ADDR_WIDTH-1:0]   hdr_src;
    logic [ET_W-1:0]             hdr_type;
    logic                        hdr_match;
    logic                        eop_acc;
    logic                        take_hdr;

    assign hdr_dst  = hdr_data[MAC_HEADER_WIDTH-1 -: MAC_ADDR_WIDTH];
    assign hdr_src  = hdr_data[MAC_HEADER_WIDTH-MAC_ADDR_WIDTH-1 -: MAC_ADDR_WIDTH];
    assign hdr_type = hdr_data[ET_W-1:0];
    assign eop_acc  = msg_valid & msg_ready & msg_eop;

`ifdef MAC_RX_CTRL_BROADCAST_EN
    assign hdr_match = (hdr_dst == FPGA_MAC) || (hdr_dst == {MAC_ADDR_WIDTH{1'b1}});
`else
    assign hdr_match = (hdr_dst == FPGA_MAC);
`endif

    always_comb begin
        state_d        = state_q;
        eop_flag_d     = eop_flag_q;
        out_hdr_data_d = out_hdr_data_q;
        fwd_cnt_d      = fwd_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        hdr_overrun_d  = 1'b0;
        take_hdr       = 1'b0;

        case (state_q)
            IDLE: take_hdr = hdr_valid;
            FWD_HDR: begin
                if (eop_acc) eop_flag_d = 1'b1;
                if (out_hdr_ready) state_d = (eop_flag_q || eop_acc) ? IDLE : FWD_BODY;
                hdr_overrun_d = hdr_valid;
            end
            FWD_BODY, DROP: begin
                // A header arriving with the closing eop starts the next frame directly.
                if (eop_acc) begin
                    state_d  = IDLE;
                    take_hdr = hdr_valid;
                end else begin
                    hdr_overrun_d = hdr_valid;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_hdr) begin
            if (hdr_match) begin
                state_d        = FWD_HDR;
                out_hdr_data_d = {hdr_src, FPGA_MAC, hdr_type};
                fwd_cnt_d      = fwd_cnt_q + 32'd1;
            end else begin
                state_d    = DROP;
                drop_cnt_d = drop_cnt_q + 32'd1;
            end
        end

        if (state_d != FWD_HDR) eop_flag_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            eop_flag_q      <= 1'b0;
            out_hdr_data_q  <= '0;
            out_hdr_valid_q <= 1'b0;
            drop_q          <= 1'b0;
            fwd_cnt_q       <= '0;
            drop_cnt_q      <= '0;
            hdr_overrun_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            eop_flag_q      <= eop_flag_d;
            out_hdr_data_q  <= out_hdr_data_d;
            out_hdr_valid_q <= (state_d == FWD_HDR);
            drop_q          <= (state_d == DROP);
            fwd_cnt_q       <= fwd_cnt_d;
            drop_cnt_q      <= drop_cnt_d;
            hdr_overrun_q   <= hdr_overrun_d;
        end
    end

    assign drop          = drop_q;
    assign out_hdr_data  = out_hdr_data_q;
    assign out_hdr_valid = out_hdr_valid_q;
    assign fwd_cnt       = fwd_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign hdr_overrun   = hdr_overrun_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mac_rx_ctrl.sv
// Bench for mac_rx_ctrl: directed scenarios plus random frames against a frame-level model.
module tb_mac_rx_ctrl;

    localparam logic [47:0] MAC   = 48'h001C24174ACB;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [111:0] hdr_data = '0;
    logic         hdr_valid = 1'b0;
    logic         msg_valid = 1'b0;
    logic         msg_ready = 1'b0;
    logic         msg_eop = 1'b0;
    logic         drop;
    logic [111:0] out_hdr_data;
    logic         out_hdr_valid;
    logic         out_hdr_ready = 1'b0;
    logic [31:0]  fwd_cnt;
    logic [31:0]  drop_cnt;
    logic         hdr_overrun;
    logic [1:0]   dbg_state;

    mac_rx_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .hdr_data      (hdr_data),
        .hdr_valid     (hdr_valid),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready),
        .msg_eop       (msg_eop),
        .drop          (drop),
        .out_hdr_data  (out_hdr_data),
        .out_hdr_valid (out_hdr_valid),
        .out_hdr_ready (out_hdr_ready),
        .fwd_cnt       (fwd_cnt),
        .drop_cnt      (drop_cnt),
        .hdr_overrun   (hdr_overrun),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    int           pass_cnt = 0;
    int           total_cnt = 0;
    logic [31:0]  exp_fwd_cnt = '0;
    logic [31:0]  exp_drop_cnt = '0;
    logic [111:0] exp_q[$];
    bit           cur_fwd = 1'b0;
    bit           bcast_en;

    task automatic chk(input string tag, input logic [111:0] obs, input logic [111:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Frame-level rule: forward iff dst is ours (or broadcast when enabled); reply swaps src in.
    task automatic model_accept(input logic [111:0] h);
        logic [47:0] dst;
        dst = h[111:64];
        cur_fwd = (dst == MAC) || (bcast_en && dst == BCAST);
        if (cur_fwd) begin
            exp_fwd_cnt++;
            exp_q.push_back({h[63:16], MAC, h[15:0]});
        end else begin
            exp_drop_cnt++;
        end
    endtask

    task automatic check_hdr_state();
        chk("hdr_drop", drop, !cur_fwd);
        chk("hdr_ohv", out_hdr_valid, cur_fwd);
        chk("hdr_fwd_cnt", fwd_cnt, exp_fwd_cnt);
        chk("hdr_drop_cnt", drop_cnt, exp_drop_cnt);
        chk("hdr_overrun_lo", hdr_overrun, 1'b0);
        if (cur_fwd) chk("hdr_data", out_hdr_data, exp_q[0]);
    endtask

    task automatic start_hdr(input logic [111:0] h);
        @(negedge clk);
        hdr_data  = h;
        hdr_valid = 1'b1;
        @(negedge clk);
        hdr_valid = 1'b0;
        model_accept(h);
        check_hdr_state();
    endtask

    // Runs payload beats (random gaps) and the reply-header handshake (ready after d cycles).
    task automatic run_body(input int n, input int d, input bit chain, input logic [111:0] next_h);
        int  beats = 0;
        int  t = 0;
        bit  pending;
        bit  v;
        bit  r;
        pending = cur_fwd;
        while ((beats < n || pending) && t < 300) begin
            chk("body_drop", drop, !cur_fwd);
            chk("body_ohv", out_hdr_valid, pending);
            if (pending) chk("body_hdr_stable", out_hdr_data, exp_q[0]);
            v = (beats < n) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            msg_valid     = v;
            msg_ready     = r;
            msg_eop       = (beats == n - 1);
            out_hdr_ready = pending && (t >= d);
            hdr_valid     = chain && v && r && (beats == n - 1);
            hdr_data      = next_h;
            @(negedge clk);
            if (v && r) beats++;
            if (out_hdr_ready) begin
                pending = 1'b0;
                void'(exp_q.pop_front());
            end
            t++;
        end
        if (t >= 300) chk("body_timeout", 1'b1, 1'b0);
        msg_valid = 1'b0; msg_ready = 1'b0; msg_eop = 1'b0;
        out_hdr_ready = 1'b0; hdr_valid = 1'b0;
        if (chain) begin
            model_accept(next_h);
            check_hdr_state();
        end else begin
            chk("end_idle", dbg_state, 2'd0);
            chk("end_drop", drop, 1'b0);
            chk("end_ohv", out_hdr_valid, 1'b0);
            chk("end_fwd_cnt", fwd_cnt, exp_fwd_cnt);
            chk("end_drop_cnt", drop_cnt, exp_drop_cnt);
        end
    endtask

    function automatic logic [111:0] rand_hdr();
        logic [63:0] a;
        logic [63:0] b;
        logic [47:0] dst;
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0:       dst = MAC;
            1:       dst = BCAST;
            2:       dst = a[47:0];
            default: dst = MAC ^ (48'h1 << $urandom_range(0, 47));
        endcase
        return {dst, b[47:0], a[63:48]};
    endfunction

    initial begin
        logic [1:0] st;
`ifdef MAC_RX_CTRL_BROADCAST_EN
        bcast_en = 1'b1;
`else
        bcast_en = 1'b0;
`endif
        #2;
        chk("rst_drop", drop, 1'b0);
        chk("rst_ohv", out_hdr_valid, 1'b0);
        chk("rst_ohd", out_hdr_data, 112'h0);
        chk("rst_fwd_cnt", fwd_cnt, 32'h0);
        chk("rst_drop_cnt", drop_cnt, 32'h0);
        chk("rst_overrun", hdr_overrun, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Matching header, reply held through a 5-cycle ready stall.
        start_hdr({MAC, 48'hAABBCCDDEEFF, 16'h0800});
        chk("match_reply", out_hdr_data, {48'hAABBCCDDEEFF, 48'h001C24174ACB, 16'h0800});
        chk("match_fwd_cnt", fwd_cnt, 32'd1);
        run_body(3, 5, 1'b0, '0);

        // Non-matching header.
        start_hdr({48'h112233445566, 48'h0A0B0C0D0E0F, 16'h0806});
        chk("nomatch_drop_cnt", drop_cnt, 32'd1);
        run_body(3, 0, 1'b0, '0);

        // Broadcast destination.
        start_hdr({BCAST, 48'h020000000001, 16'h86DD});
        run_body(2, 1, 1'b0, '0);

        // Header mid-packet in DROP: overrun pulse, nothing else moves.
        start_hdr({48'h001C24174ACA, 48'h0200000000AA, 16'h0800});
        st = dbg_state;
        @(negedge clk);
        msg_valid = 1'b1; msg_ready = 1'b1; msg_eop = 1'b0;
        hdr_data = {MAC, 48'h0200000000BB, 16'h0800}; hdr_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0; msg_ready = 1'b0; hdr_valid = 1'b0;
        chk("ovr_pulse", hdr_overrun, 1'b1);
        chk("ovr_state", dbg_state, st);
        chk("ovr_drop", drop, 1'b1);
        chk("ovr_fwd_cnt", fwd_cnt, exp_fwd_cnt);
        chk("ovr_drop_cnt", drop_cnt, exp_drop_cnt);
        @(negedge clk);
        chk("ovr_one_cycle", hdr_overrun, 1'b0);
        run_body(2, 0, 1'b0, '0);

        // Header coincident with the closing eop is taken, no overrun.
        start_hdr({48'h0000000000AA, 48'h0200000000CC, 16'h0800});
        run_body(2, 0, 1'b1, {MAC, 48'h0200000000DD, 16'h0801});
        run_body(2, 2, 1'b0, '0);

        // Drop counter wraps.
        @(negedge clk);
        force dut.drop_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.drop_cnt_q;
        exp_drop_cnt = 32'hFFFFFFFF;
        start_hdr({48'h123456789ABC, 48'h020000000011, 16'h0800});
        chk("wrap_drop_cnt", drop_cnt, 32'h0);
        run_body(1, 0, 1'b0, '0);

        // Asynchronous reset in the middle of a dropped frame.
        start_hdr({48'h0000DEADBEEF, 48'h020000000022, 16'h0800});
        @(negedge clk);
        msg_valid = 1'b1; msg_ready = 1'b1; msg_eop = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_drop", drop, 1'b0);
        chk("arst_state", dbg_state, 2'd0);
        chk("arst_fwd_cnt", fwd_cnt, 32'h0);
        chk("arst_drop_cnt", drop_cnt, 32'h0);
        exp_fwd_cnt = '0; exp_drop_cnt = '0; exp_q.delete();
        @(negedge clk);
        msg_valid = 1'b0; msg_ready = 1'b0;
        rst = 1'b0;
        start_hdr({MAC, 48'h020000000033, 16'h0800});
        chk("post_rst_fwd_cnt", fwd_cnt, 32'd1);
        run_body(2, 1, 1'b0, '0);

        // Random frames.
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_hdr(rand_hdr());
            run_body($urandom_range(1, 4), $urandom_range(0, 4), 1'b0, '0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
